systolic_array_ctrl: RTL

- Sequencer for the NxN 2D systolic multiplier built from the MAC processing elements.
- On i_start, runs one C = A x B pass with a runtime inner dimension kLen:
  - drives the common doProcess enable;
  - gives the A-row and B-column feeders per-lane valid windows and a time index for skewed injection;
  - steps a row select for result readout under a valid/ready handshake, then clears the accumulators.
- Sits between the top-level command interface and the feeder, array and result-mux logic.

---
 rtl/systolic_array_ctrl.sv | 111 +++++++++++
 1 files changed

// File: rtl/systolic_array_ctrl.sv
// Sequencer for an NxN systolic MAC array: runs FEED with skewed per-lane
// valid windows, then READ with a row handshake, then DONE to clear the PEs.

module systolic_lane_window #(
  parameter int LANE = 0,
  parameter int KW   = 8,
  parameter int CW   = 11
) (
  input  logic          en,
  input  logic [CW-1:0] t,
  input  logic [KW-1:0] k_len,
  output logic          vld
);
  // t < LANE wraps t-LANE far above any k_len, so one compare covers both bounds
  logic [CW-1:0] rel;
  assign rel = t - CW'(LANE);
  assign vld = en && (rel < CW'(k_len));
endmodule

module systolic_array_ctrl #(
  parameter int N  = 4,
  parameter int KW = 8,
  localparam int CW = KW + $clog2(2*N),
  localparam int RW = $clog2(N)
) (
  input  logic          i_clk,
  input  logic          i_rst_n,
  input  logic          i_start,
  input  logic [KW-1:0] i_kLen,
  output logic          o_busy,
  output logic          o_doProcess,
  output logic [CW-1:0] o_t,
  output logic [N-1:0]  o_aLaneValid,
  output logic [N-1:0]  o_bLaneValid,
  output logic [RW-1:0] o_rowSel,
  output logic          o_resValid,
  input  logic          i_resReady,
  output logic          o_done
);
  typedef enum logic [1:0] {IDLE, FEED, READ, DONE} state_t;

  state_t        state, state_nxt;
  logic [CW-1:0] t;
  logic [KW-1:0] k_len;
  logic [RW-1:0] row_sel;
  logic [N-1:0]  lane_vld;
  logic          feed, last_feed, row_acc, last_row;

  assign feed      = (state == FEED);
  assign last_feed = (t == CW'(k_len) + CW'(2*N-3));
  assign row_acc   = (state == READ) && i_resReady;
  assign last_row  = (row_sel == RW'(N-1));

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      state   <= IDLE;
      t       <= '0;
      k_len   <= '0;
      row_sel <= '0;
    end else begin
      state <= state_nxt;
      t     <= '0;
      if (feed && !last_feed) t <= t + CW'(1);
      if (state == IDLE && i_start) k_len <= i_kLen;
      if (row_acc) row_sel <= last_row ? '0 : row_sel + RW'(1);
    end
  end

  always_comb begin
    state_nxt   = state;
    o_busy      = 1'b1;
    o_doProcess = 1'b0;
    o_resValid  = 1'b0;
    o_done      = 1'b0;
    case (state)
      IDLE: begin
        o_busy = 1'b0;
        if (i_start) state_nxt = (i_kLen == '0) ? DONE : FEED;
      end
      FEED: begin
        o_doProcess = 1'b1;
        if (last_feed) state_nxt = READ;
      end
      READ: begin
        // lanes are idle here, so zero operands leave the accumulators unchanged
        o_doProcess = 1'b1;
        o_resValid  = 1'b1;
        if (row_acc && last_row) state_nxt = DONE;
      end
      DONE: begin
        o_done    = 1'b1;
        state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  for (genvar i = 0; i < N; i++) begin : g_lane
    systolic_lane_window #(.LANE(i), .KW(KW), .CW(CW)) u_win (
      .en   (feed),
      .t    (t),
      .k_len(k_len),
      .vld  (lane_vld[i])
    );
  end

  assign o_t          = t;
  assign o_aLaneValid = lane_vld;
  assign o_bLaneValid = lane_vld;
  assign o_rowSel     = row_sel;
endmodule
